// File: rtl/dram_ctrl.sv
// dram_ctrl: word-organised backing memory answering sized loads/stores after a fixed latency.
// Define DRAM_CTRL_MISALIGN_EN to allow accesses at any lane that stay within one 8-byte word.
module dram_ctrl #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int unsigned MEM_BYTES = 65536,
    parameter int unsigned LATENCY   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] addr,
    input  logic [63:0] din,
    input  logic [2:0]  rd_ctrl,
    input  logic [2:0]  wr_ctrl,
    output logic [63:0] dout,
    output logic [1:0]  state,
    output logic        ack
);

    localparam int unsigned WORDS = MEM_BYTES / 8;
    localparam int unsigned AW    = $clog2(MEM_BYTES);
    localparam int unsigned CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RBUSY = 3'd1;
    localparam logic [2:0] WBUSY = 3'd2;
    localparam logic [2:0] RESP  = 3'd3;
    localparam logic [2:0] ERR   = 3'd4;

    logic [63:0] mem [WORDS];

    logic [2:0]    fsm_q, fsm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-4:0] idx_q;
    logic [2:0]    lane_q;
    logic [3:0]    size_q;
    logic [2:0]    rd_q;
    logic [63:0]   din_q;
    logic [63:0]   dout_q;

    logic [63:0] offset;
    logic [3:0]  rd_size, wr_size, size;
    logic [2:0]  lane;
    logic        req, accept, last_busy;
    logic        both_err, rsvd_err, range_err, cross_err, align_err, req_err;

    always_comb begin
        rd_size = 4'd0;
        case (rd_ctrl)
            3'b001, 3'b010: rd_size = 4'd1;
            3'b011, 3'b100: rd_size = 4'd2;
            3'b101, 3'b111: rd_size = 4'd4;
            3'b110:         rd_size = 4'd8;
            default:        rd_size = 4'd0;
        endcase
        wr_size = 4'd0;
        case (wr_ctrl)
            3'b001:  wr_size = 4'd1;
            3'b010:  wr_size = 4'd2;
            3'b011:  wr_size = 4'd4;
            3'b100:  wr_size = 4'd8;
            default: wr_size = 4'd0;
        endcase
    end

    assign size      = (rd_ctrl != 3'b000) ? rd_size : wr_size;
    assign offset    = addr - BASE_ADDR;
    assign lane      = addr[2:0];
    assign req       = (rd_ctrl != 3'b000) || (wr_ctrl != 3'b000);
    assign accept    = (fsm_q == IDLE) && req;
    assign last_busy = (cnt_q == LAST);

    // Addresses below BASE_ADDR wrap to huge offsets and fail the same range test.
    assign both_err  = (rd_ctrl != 3'b000) && (wr_ctrl != 3'b000);
    assign rsvd_err  = (wr_ctrl >= 3'b101);
    assign range_err = (offset >= 64'(MEM_BYTES));
    assign cross_err = (({1'b0, lane} + size) > 4'd8);
`ifdef DRAM_CTRL_MISALIGN_EN
    assign align_err = 1'b0;
`else
    assign align_err = ((size == 4'd2) && lane[0]) ||
                       ((size == 4'd4) && (lane[1:0] != 2'b00)) ||
                       ((size == 4'd8) && (lane != 3'b000));
`endif
    assign req_err   = both_err || rsvd_err || range_err || cross_err || align_err;

    logic [63:0] word, rshift, rdata, wshift, merged;
    logic [7:0]  mask, be;

    assign word   = mem[idx_q];
    assign rshift = word >> {lane_q, 3'b000};
    assign wshift = din_q << {lane_q, 3'b000};

    always_comb begin
        rdata = rshift;
        case (rd_q)
            3'b001:  rdata = {{56{rshift[7]}}, rshift[7:0]};
            3'b010:  rdata = {56'd0, rshift[7:0]};
            3'b011:  rdata = {{48{rshift[15]}}, rshift[15:0]};
            3'b100:  rdata = {48'd0, rshift[15:0]};
            3'b101:  rdata = {{32{rshift[31]}}, rshift[31:0]};
            3'b111:  rdata = {32'd0, rshift[31:0]};
            default: rdata = rshift;
        endcase
    end

    always_comb begin
        mask = 8'h00;
        case (size_q)
            4'd1:    mask = 8'h01;
            4'd2:    mask = 8'h03;
            4'd4:    mask = 8'h0F;
            4'd8:    mask = 8'hFF;
            default: mask = 8'h00;
        endcase
        be     = mask << lane_q;
        merged = word;
        for (int b = 0; b < 8; b++) begin
            if (be[b]) merged[b*8 +: 8] = wshift[b*8 +: 8];
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        case (fsm_q)
            IDLE: begin
                if (req) begin
                    cnt_d = '0;
                    if (req_err)                     fsm_d = ERR;
                    else if (rd_ctrl != 3'b000)      fsm_d = RBUSY;
                    else                             fsm_d = WBUSY;
                end
            end
            RBUSY, WBUSY: begin
                if (last_busy) fsm_d = RESP;
                else           cnt_d = cnt_q + 1'b1;
            end
            RESP, ERR: fsm_d = IDLE;
            default:   fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q  <= IDLE;
            cnt_q  <= '0;
            dout_q <= '0;
            idx_q  <= '0;
            lane_q <= '0;
            size_q <= '0;
            rd_q   <= '0;
            din_q  <= '0;
        end else begin
            fsm_q <= fsm_d;
            cnt_q <= cnt_d;
            if (accept) begin
                idx_q  <= offset[AW-1:3];
                lane_q <= lane;
                size_q <= size;
                rd_q   <= rd_ctrl;
                din_q  <= din;
            end
            if (accept && req_err)                  dout_q <= '0;
            else if ((fsm_q == RBUSY) && last_busy) dout_q <= rdata;
        end
    end

    // Memory is never cleared; a reset on the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (!rst && (fsm_q == WBUSY) && last_busy) mem[idx_q] <= merged;
    end

    always_comb begin
        state = 2'b00;
        case (fsm_q)
            RBUSY:   state = 2'b01;
            WBUSY:   state = 2'b10;
            ERR:     state = 2'b11;
            default: state = 2'b00;
        endcase
    end

    assign ack  = (fsm_q == RESP) || (fsm_q == ERR);
    assign dout = dout_q;

endmodule

// File: tb/tb_dram_ctrl.sv
// Self-checking bench for dram_ctrl: vector table, hand-written corner sequences, random traffic.
module tb_dram_ctrl;

    localparam logic [63:0] BASE      = 64'h0000_0000_8000_0000;
    localparam int unsigned MEM_BYTES = 65536;
    localparam int unsigned LATENCY   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] addr, din, dout;
    logic [2:0]  rd_ctrl, wr_ctrl;
    logic [1:0]  state;
    logic        ack;

    always #5 clk = ~clk;

    dram_ctrl #(
        .BASE_ADDR (BASE),
        .MEM_BYTES (MEM_BYTES),
        .LATENCY   (LATENCY)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .din     (din),
        .rd_ctrl (rd_ctrl),
        .wr_ctrl (wr_ctrl),
        .dout    (dout),
        .state   (state),
        .ack     (ack)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] d;
        logic [2:0]  rd;
        logic [2:0]  wr;
        bit          err;
        logic [63:0] exp;
    } vec_t;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [63:0] last_dout;
    logic [7:0]  model_mem [256];   // model of the first 256 bytes above BASE
    vec_t        vecs [22];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        addr = '0; din = '0; rd_ctrl = '0; wr_ctrl = '0;
    endtask

    function automatic int unsigned rd_size(input logic [2:0] c);
        case (c)
            3'd1, 3'd2: return 1;
            3'd3, 3'd4: return 2;
            3'd5, 3'd7: return 4;
            3'd6:       return 8;
            default:    return 0;
        endcase
    endfunction

    function automatic int unsigned wr_size(input logic [2:0] c);
        case (c)
            3'd1:    return 1;
            3'd2:    return 2;
            3'd3:    return 4;
            3'd4:    return 8;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_err(input logic [63:0] a, input logic [2:0] rd,
                                     input logic [2:0] wr);
        logic [63:0] off;
        int unsigned sz, lane;
        if (rd != 0 && wr != 0) return 1'b1;
        if (rd == 0 && wr >= 3'd5) return 1'b1;
        off = a - BASE;
        if (off >= 64'(MEM_BYTES)) return 1'b1;
        sz   = (rd != 0) ? rd_size(rd) : wr_size(wr);
        lane = 32'(a % 64'd8);
        if (lane + sz > 8) return 1'b1;
`ifndef DRAM_CTRL_MISALIGN_EN
        if (a % 64'(sz) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [63:0] model_read(input logic [63:0] a, input logic [2:0] rd);
        logic [7:0]  off;
        logic [63:0] v;
        int unsigned sz;
        off = 8'(a - BASE);
        sz  = rd_size(rd);
        v   = 64'd0;
        for (int i = 0; i < int'(sz); i++) v = v | (64'(model_mem[off + 8'(i)]) << (8 * i));
        if ((rd == 3'd1 || rd == 3'd3 || rd == 3'd5) && v[8*sz-1])
            v = v | ~((64'd1 << (8 * sz)) - 64'd1);
        return v;
    endfunction

    task automatic model_write(input logic [63:0] a, input logic [63:0] d, input logic [2:0] wr);
        logic [7:0] off;
        off = 8'(a - BASE);
        for (int i = 0; i < int'(wr_size(wr)); i++) model_mem[off + 8'(i)] = d[8*i +: 8];
    endtask

    // One full transaction from accept to the following idle cycle, checking every cycle.
    task automatic transact(input logic [63:0] a, input logic [63:0] d, input logic [2:0] rd,
                            input logic [2:0] wr, input bit noise, input bit exp_err,
                            input logic [63:0] exp_dout, input string name);
        logic [63:0] busy_code;
        addr = a; din = d; rd_ctrl = rd; wr_ctrl = wr;
        step();
        idle_inputs();
        if (exp_err) begin
            check({name, ".err_state"}, 64'(state), 64'd3);
            check({name, ".err_ack"}, 64'(ack), 64'd1);
            check({name, ".err_dout"}, dout, 64'd0);
            last_dout = 64'd0;
            step();
        end else begin
            busy_code = (rd != 0) ? 64'd1 : 64'd2;
            for (int i = 0; i < int'(LATENCY); i++) begin
                check({name, ".busy"}, 64'(state), busy_code);
                check({name, ".busy_ack"}, 64'(ack), 64'd0);
                if (noise) begin
                    addr = {$urandom, $urandom}; din = {$urandom, $urandom};
                    rd_ctrl = 3'($urandom); wr_ctrl = 3'($urandom);
                end
                step();
            end
            idle_inputs();
            check({name, ".resp_state"}, 64'(state), 64'd0);
            check({name, ".resp_ack"}, 64'(ack), 64'd1);
            if (rd != 0) last_dout = exp_dout;
            check({name, ".resp_dout"}, dout, last_dout);
            step();
        end
        check({name, ".idle_state"}, 64'(state), 64'd0);
        check({name, ".idle_ack"}, 64'(ack), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{64'h8000_0010, 64'h1122_3344_5566_7788, 3'd0, 3'd4, 1'b0, 64'h0};
        vecs[1]  = '{64'h8000_0010, 64'h0, 3'd6, 3'd0, 1'b0, 64'h1122_3344_5566_7788};
        vecs[2]  = '{64'h8000_0013, 64'hAAAA_AAAA_AAAA_AAF0, 3'd0, 3'd1, 1'b0, 64'h0};
        vecs[3]  = '{64'h8000_0013, 64'h0, 3'd1, 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0};
        vecs[4]  = '{64'h8000_0013, 64'h0, 3'd2, 3'd0, 1'b0, 64'h0000_0000_0000_00F0};
        vecs[5]  = '{64'h8000_0010, 64'h0, 3'd6, 3'd0, 1'b0, 64'h1122_3344_F066_7788};
        vecs[6]  = '{64'h7FFF_FFF8, 64'h0, 3'd6, 3'd0, 1'b1, 64'h0};
        vecs[7]  = '{64'h8001_0000, 64'h0, 3'd6, 3'd0, 1'b1, 64'h0};
        vecs[8]  = '{64'h8000_0010, 64'h0, 3'd6, 3'd0, 1'b0, 64'h1122_3344_F066_7788};
`ifdef DRAM_CTRL_MISALIGN_EN
        vecs[9]  = '{64'h8000_0011, 64'h0, 3'd3, 3'd0, 1'b0, 64'h0000_0000_0000_6677};
`else
        vecs[9]  = '{64'h8000_0011, 64'h0, 3'd3, 3'd0, 1'b1, 64'h0};
`endif
        vecs[10] = '{64'h8000_0016, 64'h0, 3'd5, 3'd0, 1'b1, 64'h0};
        vecs[11] = '{64'h8000_0010, 64'h0, 3'd6, 3'd4, 1'b1, 64'h0};
        vecs[12] = '{64'h8000_0018, 64'h0, 3'd0, 3'd5, 1'b1, 64'h0};
        vecs[13] = '{64'h8000_0020, 64'h1234_5678_9ABC_8001, 3'd0, 3'd2, 1'b0, 64'h0};
        vecs[14] = '{64'h8000_0020, 64'h0, 3'd3, 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_8001};
        vecs[15] = '{64'h8000_0020, 64'h0, 3'd4, 3'd0, 1'b0, 64'h0000_0000_0000_8001};
        vecs[16] = '{64'h8000_0024, 64'h5555_5555_DEAD_BEEF, 3'd0, 3'd3, 1'b0, 64'h0};
        vecs[17] = '{64'h8000_0024, 64'h0, 3'd5, 3'd0, 1'b0, 64'hFFFF_FFFF_DEAD_BEEF};
        vecs[18] = '{64'h8000_0024, 64'h0, 3'd7, 3'd0, 1'b0, 64'h0000_0000_DEAD_BEEF};
        vecs[19] = '{64'h8000_0020, 64'h0, 3'd6, 3'd0, 1'b0, 64'hDEAD_BEEF_0000_8001};
        vecs[20] = '{64'h8000_002C, 64'h0, 3'd0, 3'd4, 1'b1, 64'h0};
        vecs[21] = '{64'h8000_0027, 64'h0, 3'd1, 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFDE};

        rst = 1'b1;
        idle_inputs();
        last_dout = 64'd0;
        repeat (3) step();
        check("reset.state", 64'(state), 64'd0);
        check("reset.ack", 64'(ack), 64'd0);
        check("reset.dout", dout, 64'd0);
        rst = 1'b0;

        for (int w = 0; w < 32; w++)
            transact(BASE + 64'(w * 8), 64'h0, 3'd0, 3'd4, 1'b0, 1'b0, 64'h0, "init");
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;

        for (int i = 0; i < 22; i++) begin
            transact(vecs[i].a, vecs[i].d, vecs[i].rd, vecs[i].wr, 1'b0, vecs[i].err,
                     vecs[i].exp, $sformatf("vec%0d", i));
            if (!vecs[i].err && vecs[i].wr != 0) model_write(vecs[i].a, vecs[i].d, vecs[i].wr);
        end

        // Inputs toggled during a read are ignored; nothing else gets written either.
        transact(BASE + 64'h10, 64'h0, 3'd6, 3'd0, 1'b1, 1'b0, model_read(BASE + 64'h10, 3'd6),
                 "noise_rd");
        transact(BASE + 64'h10, 64'h0, 3'd6, 3'd0, 1'b0, 1'b0, model_read(BASE + 64'h10, 3'd6),
                 "noise_after");

        // Request held through RESP is only taken in the following idle cycle.
        addr = BASE + 64'h10; din = 64'h0; rd_ctrl = 3'd6; wr_ctrl = 3'd0;
        step();
        for (int i = 0; i < int'(LATENCY); i++) begin
            check("hold.busy", 64'(state), 64'd1);
            step();
        end
        check("hold.resp_ack", 64'(ack), 64'd1);
        check("hold.resp_dout", dout, 64'h1122_3344_F066_7788);
        step();
        check("hold.idle_state", 64'(state), 64'd0);
        check("hold.idle_ack", 64'(ack), 64'd0);
        step();
        check("hold.reaccept", 64'(state), 64'd1);
        idle_inputs();
        repeat (LATENCY) step();
        check("hold.resp2_ack", 64'(ack), 64'd1);
        check("hold.resp2_dout", dout, 64'h1122_3344_F066_7788);
        step();
        check("hold.idle2", 64'(state), 64'd0);
        last_dout = 64'h1122_3344_F066_7788;

        // Reset during a store aborts it.
        transact(BASE + 64'h40, 64'h0123_4567_89AB_CDEF, 3'd0, 3'd4, 1'b0, 1'b0, 64'h0, "old");
        model_write(BASE + 64'h40, 64'h0123_4567_89AB_CDEF, 3'd4);
        addr = BASE + 64'h40; din = 64'hCAFE_F00D_CAFE_F00D; rd_ctrl = 3'd0; wr_ctrl = 3'd4;
        step();
        idle_inputs();
        check("rstw.busy1", 64'(state), 64'd2);
        step();
        check("rstw.busy2", 64'(state), 64'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstw.state", 64'(state), 64'd0);
        check("rstw.ack", 64'(ack), 64'd0);
        check("rstw.dout", dout, 64'd0);
        last_dout = 64'd0;
        transact(BASE + 64'h40, 64'h0, 3'd6, 3'd0, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF,
                 "rstw.read");

        for (int n = 0; n < 300; n++) begin
            logic [63:0] a, d, exp;
            logic [2:0]  rd, wr;
            int unsigned kind, sz;
            bit          e;
            kind = $urandom_range(0, 9);
            rd = 3'd0;
            wr = 3'd0;
            if (kind <= 3) wr = 3'($urandom_range(1, 4));
            else if (kind <= 7) rd = 3'($urandom_range(1, 7));
            else if (kind == 8) begin
                rd = 3'($urandom_range(1, 7));
                wr = 3'($urandom_range(1, 7));
            end else wr = 3'($urandom_range(5, 7));
            sz = (rd != 0) ? rd_size(rd) : wr_size(wr);
            if (sz == 0) sz = 1;
            a = BASE + 64'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) a = a - (a % 64'(sz));
            if ($urandom_range(0, 9) == 0)
                a = ($urandom_range(0, 1) == 0) ? BASE - 64'($urandom_range(1, 64))
                                                : BASE + 64'(MEM_BYTES) + 64'($urandom_range(0, 255));
            d   = {$urandom, $urandom};
            e   = model_err(a, rd, wr);
            exp = (!e && rd != 0) ? model_read(a, rd) : 64'h0;
            transact(a, d, rd, wr, ($urandom_range(0, 3) == 0), e, exp, $sformatf("rand%0d", n));
            if (!e && wr != 0) model_write(a, d, wr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
